// File: rtl/ring_tracker_pkg.sv
// ring_tracker_pkg
//   Shared types and helpers for the ring index tracker.
//   - ring_op_t  : command opcodes carried on cmd_op
//   - ch_state_t : per-channel FSM state (IDLE / ROTATING)
//   - onehot_to_index() : binary position of the set bit in a one-hot ring
//     of up to MAX_RING_W bits (callers zero-extend narrower rings).
//   Optional feature macro used by the design: RING_WRAP_COUNT_EN.
package ring_tracker_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    STEP     = 2'd1,
    LOAD     = 2'd2,
    ROTATE_N = 2'd3
  } ring_op_t;

  typedef enum logic {
    IDLE     = 1'b0,
    ROTATING = 1'b1
  } ch_state_t;

  // Widest ring the encoder helper accepts.
  localparam int MAX_RING_W = 256;

  // OR together the positions of all set bits; for a one-hot input this is
  // exactly the index of the single set bit.
  function automatic int onehot_to_index(input logic [MAX_RING_W-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_RING_W; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_channel.sv
// ring_channel
//   One one-hot ring with its command FSM, rotation counter and registered
//   binary index. With RING_WRAP_COUNT_EN defined it also keeps a signed-ish
//   modulo-256 wrap counter (+1 per forward wrap, -1 per backward wrap).
// Ports
//   clock, reset : posedge clock, synchronous active-high reset
//   start        : a command for this channel is accepted this cycle
//   op/dir/arg   : the accepted command (only meaningful with start)
//   ring         : one-hot ring, reset value 'b1
//   index        : encode(ring) registered one cycle later
//   state        : FSM state (ROTATING means the channel is busy)
//   done         : one-cycle pulse after a command completes
//   wrap_count   : (RING_WRAP_COUNT_EN only) wrap counter
module ring_channel
  import ring_tracker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  ring_op_t         op,
  input  logic             dir,
  input  logic [IDX_W-1:0] arg,
  output logic [WIDTH-1:0] ring,
  output logic [IDX_W-1:0] index,
  output ch_state_t        state,
  output logic             done
`ifdef RING_WRAP_COUNT_EN
  ,
  output logic [7:0]       wrap_count
`endif
);

  localparam logic [WIDTH-1:0] RING_RESET = {{(WIDTH-1){1'b0}}, 1'b1};

  ch_state_t        state_n;
  logic [WIDTH-1:0] ring_n;
  logic [IDX_W-1:0] cnt, cnt_n;
  logic             dir_q, dir_n;
  logic             done_n;
  logic             step_en, step_dir, load_en;

  // Next-state / control decode.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dir_n    = dir_q;
    done_n   = 1'b0;
    step_en  = 1'b0;
    step_dir = dir;
    load_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (op)
            HOLD: done_n = 1'b1;
            STEP: begin
              step_en = 1'b1;
              done_n  = 1'b1;
            end
            LOAD: begin
              load_en = 1'b1;
              done_n  = 1'b1;
            end
            ROTATE_N: begin
              // A zero count behaves like HOLD and never leaves IDLE.
              if (arg == '0) begin
                done_n = 1'b1;
              end else begin
                state_n = ROTATING;
                cnt_n   = arg;
                dir_n   = dir;
              end
            end
            default: ;
          endcase
        end
      end
      ROTATING: begin
        step_en  = 1'b1;
        step_dir = dir_q;
        cnt_n    = cnt - 1'b1;
        // Last step: leave ROTATING on the same edge that makes the final move.
        if (cnt == IDX_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Ring datapath: LOAD builds a fresh one-hot value, steps rotate by one.
  always_comb begin
    ring_n = ring;
    if (load_en) begin
      ring_n = RING_RESET << arg;
    end else if (step_en) begin
      if (step_dir) ring_n = {ring[0], ring[WIDTH-1:1]};
      else          ring_n = {ring[WIDTH-2:0], ring[WIDTH-1]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ring  <= RING_RESET;
      cnt   <= '0;
      dir_q <= 1'b0;
      done  <= 1'b0;
      index <= '0;
    end else begin
      state <= state_n;
      ring  <= ring_n;
      cnt   <= cnt_n;
      dir_q <= dir_n;
      done  <= done_n;
      // Encodes the current ring, so index trails ring by one cycle.
      index <= IDX_W'(onehot_to_index(MAX_RING_W'(ring)));
    end
  end

`ifdef RING_WRAP_COUNT_EN
  // A forward wrap is a step out of the top bit, a backward wrap a step out
  // of bit 0. LOAD never counts, even if it jumps across the boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrap_count <= 8'd0;
    end else if (step_en) begin
      if (!step_dir && ring[WIDTH-1])
        wrap_count <= wrap_count + 8'd1;
      else if (step_dir && ring[0])
        wrap_count <= wrap_count - 8'd1;
    end
  end
`endif

endmodule

// File: rtl/ring_index_tracker.sv
// ring_index_tracker
//   Multi-channel one-hot ring position tracker with a shared command port.
//   Holds command decode and ready only; each ring lives in a ring_channel.
//   Optional feature macro: RING_WRAP_COUNT_EN adds the wrap_count output.
// Ports
//   clock, reset  : posedge clock, synchronous active-high reset
//   cmd_valid     : command offered
//   cmd_ready     : command accepted this cycle when cmd_valid & cmd_ready
//   cmd_ch        : target channel (values >= NUM_CH are accepted and dropped)
//   cmd_op        : ring_op_t opcode (HOLD/STEP/LOAD/ROTATE_N)
//   cmd_dir       : 0 = forward (towards higher bits), 1 = backward
//   cmd_arg       : LOAD target index / ROTATE_N step count
//   ring          : per-channel one-hot rings, ch0 in the LSBs
//   indices       : per-channel registered binary index (lags ring by 1)
//   busy          : per-channel ROTATE_N in progress
//   done          : per-channel one-cycle completion pulse
//   wrap_count    : (RING_WRAP_COUNT_EN only) per-channel 8-bit wrap counter
//
// Handshake: a command transfers on a clock edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on cmd_ch and the target
// channel's busy flag, never on cmd_valid; the source keeps cmd_* stable
// until the transfer happens.
module ring_index_tracker
  import ring_tracker_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int WIDTH  = 8,
  localparam int IDX_W  = $clog2(WIDTH),
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CH_W-1:0]         cmd_ch,
  input  logic [1:0]              cmd_op,
  input  logic                    cmd_dir,
  input  logic [IDX_W-1:0]        cmd_arg,
  output logic [NUM_CH*WIDTH-1:0] ring,
  output logic [NUM_CH*IDX_W-1:0] indices,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
`ifdef RING_WRAP_COUNT_EN
  ,
  output logic [NUM_CH*8-1:0]     wrap_count
`endif
);

  logic      [NUM_CH-1:0] start;
  ch_state_t              ch_state [NUM_CH];
  logic                   accept;

  // Only a busy, in-range target channel can stall the port; out-of-range
  // channels match no loop iteration and are therefore always ready.
  always_comb begin
    cmd_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cmd_ch == CH_W'(c) && busy[c]) cmd_ready = 1'b0;
    end
  end

  assign accept = cmd_valid & cmd_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign start[c] = accept && (cmd_ch == CH_W'(c));
    assign busy[c]  = (ch_state[c] == ROTATING);

    ring_channel #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .start      (start[c]),
      .op         (ring_op_t'(cmd_op)),
      .dir        (cmd_dir),
      .arg        (cmd_arg),
      .ring       (ring[c*WIDTH +: WIDTH]),
      .index      (indices[c*IDX_W +: IDX_W]),
      .state      (ch_state[c]),
      .done       (done[c])
`ifdef RING_WRAP_COUNT_EN
      ,
      .wrap_count (wrap_count[c*8 +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_ring_index_tracker.sv
`timescale 1ns/1ps
module tb_ring_index_tracker;
  import ring_tracker_pkg::*;

  localparam int NUM_CH = 2;
  localparam int WIDTH  = 8;
  localparam int IDX_W  = 3;
  localparam int CH_W   = 1;
  localparam int EW     = WIDTH + 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- main DUT (2 x 8) ----------------
  logic                    cmd_valid, cmd_ready, cmd_dir;
  logic [CH_W-1:0]         cmd_ch;
  logic [1:0]              cmd_op;
  logic [IDX_W-1:0]        cmd_arg;
  logic [NUM_CH*WIDTH-1:0] ring;
  logic [NUM_CH*IDX_W-1:0] indices;
  logic [NUM_CH-1:0]       busy, done;
`ifdef RING_WRAP_COUNT_EN
  logic [NUM_CH*8-1:0]     wrap_count;
`endif

  ring_index_tracker #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_arg(cmd_arg),
    .ring(ring), .indices(indices), .busy(busy), .done(done)
`ifdef RING_WRAP_COUNT_EN
    , .wrap_count(wrap_count)
`endif
  );

  // ---------------- second DUT (3 x 4) for out-of-range channel ----------------
  logic        c3_valid, c3_ready, c3_dir;
  logic [1:0]  c3_ch, c3_op, c3_arg;
  logic [11:0] c3_ring;
  logic [5:0]  c3_idx;
  logic [2:0]  c3_busy, c3_done;
`ifdef RING_WRAP_COUNT_EN
  logic [23:0] c3_wrap;
`endif

  ring_index_tracker #(.NUM_CH(3), .WIDTH(4)) dut3 (
    .clock(clock), .reset(reset), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_ch(c3_ch), .cmd_op(c3_op), .cmd_dir(c3_dir), .cmd_arg(c3_arg),
    .ring(c3_ring), .indices(c3_idx), .busy(c3_busy), .done(c3_done)
`ifdef RING_WRAP_COUNT_EN
    , .wrap_count(c3_wrap)
`endif
  );

  // ---------------- counters and check helpers ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Positions are plain integers; rings are derived as 1 << pos.
  bit               started = 1'b0;
  int               pos    [NUM_CH];
  int               rem    [NUM_CH];
  logic             rdir   [NUM_CH];
  logic [7:0]       wrap_m [NUM_CH];
  int               idx_m  [NUM_CH];
  logic [NUM_CH-1:0] done_m;
  logic [EW-1:0]    exp_q  [NUM_CH][$];

  function automatic logic [WIDTH-1:0] onehot(input int p);
    logic [WIDTH-1:0] v;
    v = 1;
    return v << p;
  endfunction

  function automatic logic model_ready(input int ch);
    if (ch >= NUM_CH) return 1'b1;
    return rem[ch] == 0;
  endfunction

  task automatic move(input int c, input logic d);
    if (!d) begin
      if (pos[c] == WIDTH-1) wrap_m[c] = wrap_m[c] + 8'd1;
      pos[c] = (pos[c] + 1) % WIDTH;
    end else begin
      if (pos[c] == 0) wrap_m[c] = wrap_m[c] - 8'd1;
      pos[c] = (pos[c] + WIDTH - 1) % WIDTH;
    end
  endtask

  task automatic model_step();
    int         ch, fp, k;
    logic [7:0] fw;
    logic       rdy;
    if (reset) begin
      started = 1'b1;
      done_m  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pos[c] = 0; rem[c] = 0; rdir[c] = 1'b0; wrap_m[c] = 8'd0; idx_m[c] = 0;
        exp_q[c].delete();
      end
    end else if (started) begin
      ch  = int'(cmd_ch);
      rdy = model_ready(ch);
      done_m = '0;
      for (int c = 0; c < NUM_CH; c++) idx_m[c] = pos[c];
      for (int c = 0; c < NUM_CH; c++) begin
        if (rem[c] > 0) begin
          move(c, rdir[c]);
          rem[c]--;
          if (rem[c] == 0) done_m[c] = 1'b1;
        end
      end
      if (cmd_valid && rdy && ch < NUM_CH) begin
        // Predict the final state of the command directly with arithmetic.
        fp = pos[ch];
        fw = wrap_m[ch];
        k  = int'(cmd_arg);
        case (cmd_op)
          2'd1: begin
            if (!cmd_dir) begin
              if (fp == WIDTH-1) fw = fw + 8'd1;
              fp = (fp + 1) % WIDTH;
            end else begin
              if (fp == 0) fw = fw - 8'd1;
              fp = (fp + WIDTH - 1) % WIDTH;
            end
          end
          2'd2: fp = k;
          2'd3: begin
            if (!cmd_dir) begin
              if (fp + k >= WIDTH) fw = fw + 8'd1;
              fp = (fp + k) % WIDTH;
            end else begin
              if (fp < k) fw = fw - 8'd1;
              fp = (fp - k + WIDTH) % WIDTH;
            end
          end
          default: ;
        endcase
        exp_q[ch].push_back({fw, onehot(fp)});
        if (cmd_op == 2'd3 && k > 0) begin
          rem[ch]  = k;
          rdir[ch] = cmd_dir;
        end else begin
          pos[ch]    = fp;
          wrap_m[ch] = fw;
          done_m[ch] = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor_step();
    logic [EW-1:0] e;
    if (!started) return;
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("ring%0d", c), 32'(ring[c*WIDTH +: WIDTH]), 32'(onehot(pos[c])));
      chk($sformatf("indices%0d", c), 32'(indices[c*IDX_W +: IDX_W]), 32'(idx_m[c]));
      chk($sformatf("busy%0d", c), 32'(busy[c]), 32'(rem[c] > 0));
      chk($sformatf("done%0d", c), 32'(done[c]), 32'(done_m[c]));
`ifdef RING_WRAP_COUNT_EN
      chk($sformatf("wrap%0d", c), 32'(wrap_count[c*8 +: 8]), 32'(wrap_m[c]));
`endif
      if (done[c]) begin
        if (exp_q[c].size() == 0) begin
          fail($sformatf("done%0d_unexpected", c));
        end else begin
          e = exp_q[c].pop_front();
          chk($sformatf("final_ring%0d", c), 32'(ring[c*WIDTH +: WIDTH]), 32'(e[WIDTH-1:0]));
`ifdef RING_WRAP_COUNT_EN
          chk($sformatf("final_wrap%0d", c), 32'(wrap_count[c*8 +: 8]), 32'(e[EW-1:WIDTH]));
`endif
        end
      end
    end
    chk("cmd_ready", 32'(cmd_ready), 32'(model_ready(int'(cmd_ch))));
  endtask

  initial forever begin
    @(negedge clock);
    monitor_step();
  end

  // ---------------- driver ----------------
  task automatic issue(input int ch, input int op, input logic d, input int arg);
    bit got;
    got       = 1'b0;
    cmd_ch    = CH_W'(ch);
    cmd_op    = 2'(op);
    cmd_dir   = d;
    cmd_arg   = IDX_W'(arg);
    cmd_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail("issue_timeout");
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    cmd_valid = 1'b0; cmd_ch = '0; cmd_op = '0; cmd_dir = 1'b0; cmd_arg = '0;
    c3_valid = 1'b0; c3_ch = '0; c3_op = '0; c3_dir = 1'b0; c3_arg = '0;

    // Reset held for two edges.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_ring", 32'(ring), 32'h0101);
    chk("reset_indices", 32'(indices), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_ready", 32'(cmd_ready), 32'h1);
    sync();

    // ch0 forward steps all the way around.
    for (int i = 0; i < 8; i++) issue(0, STEP, 1'b0, 0);
    @(negedge clock);
    chk("step_fwd_ring0", 32'(ring[7:0]), 32'h01);
`ifdef RING_WRAP_COUNT_EN
    chk("step_fwd_wrap0", 32'(wrap_count[7:0]), 32'h01);
`endif
    sync();

    // ch1 LOAD 5, then six backward steps through the wrap.
    issue(1, LOAD, 1'b0, 5);
    for (int i = 0; i < 6; i++) issue(1, STEP, 1'b1, 0);
    @(negedge clock);
    chk("bwd_ring1", 32'(ring[15:8]), 32'h80);
    @(negedge clock);
    chk("bwd_indices1", 32'(indices[5:3]), 32'h7);
`ifdef RING_WRAP_COUNT_EN
    chk("bwd_wrap1", 32'(wrap_count[15:8]), 32'hFF);
`endif
    sync();

    // ch0 ROTATE_N 3 forward from index 6 while ch1 keeps working.
    issue(0, LOAD, 1'b0, 6);
    issue(0, ROTATE_N, 1'b0, 3);
    issue(1, STEP, 1'b0, 0);
    cmd_ch = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) chk("rot_ready0_low", 32'(cmd_ready), 32'h0);
      if (done[0]) cnt++;
    end
    chk("rot_done0_count", 32'(cnt), 32'h1);
    chk("rot_ring0", 32'(ring[7:0]), 32'h02);
    sync();

    // ROTATE_N 0 acts as HOLD; ring1 was 80 then stepped forward to 01.
    issue(1, ROTATE_N, 1'b0, 0);
    @(negedge clock);
    chk("rot0_done1", 32'(done[1]), 32'h1);
    chk("rot0_busy1", 32'(busy[1]), 32'h0);
    chk("rot0_ring1", 32'(ring[15:8]), 32'h01);
    sync();

    // Out-of-range channel on a 3-channel instance: accepted, no effect.
    c3_ch = 2'd3; c3_op = 2'd1; c3_dir = 1'b0; c3_valid = 1'b1;
    @(negedge clock);
    chk("oor_ready", 32'(c3_ready), 32'h1);
    sync();
    c3_valid = 1'b0;
    @(negedge clock);
    chk("oor_ring", 32'(c3_ring), 32'h111);
    chk("oor_done", 32'(c3_done), 32'h0);
    chk("oor_busy", 32'(c3_busy), 32'h0);
    sync();
    c3_ch = 2'd2; c3_valid = 1'b1;
    @(negedge clock);
    chk("ch2_ready", 32'(c3_ready), 32'h1);
    sync();
    c3_valid = 1'b0;
    @(negedge clock);
    chk("ch2_ring", 32'(c3_ring), 32'h211);
    chk("ch2_done", 32'(c3_done), 32'h4);
    @(negedge clock);
    chk("ch2_indices", 32'(c3_idx), 32'h10);
`ifdef RING_WRAP_COUNT_EN
    chk("ch2_wrap", 32'(c3_wrap), 32'h0);
`endif
    sync();

    // Reset in the middle of ROTATE_N 7 on ch0, after its fourth step.
    issue(0, ROTATE_N, 1'b0, 7);
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_ring0", 32'(ring[7:0]), 32'h01);
    chk("abort_busy0", 32'(busy[0]), 32'h0);
    chk("abort_indices0", 32'(indices[2:0]), 32'h0);
    chk("abort_done0", 32'(done[0]), 32'h0);
    sync();

    // Random command stream against the model.
    repeat (250) begin
      issue($urandom_range(0, 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end

    // Drain and make sure every predicted completion was seen.
    repeat (12) @(negedge clock);
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("queue%0d_empty", c), 32'(exp_q[c].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
